// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access controller: owns MAR/MDR, runs the MIO_EN/R_W/R handshake and
// routes accesses to external memory or the keyboard/display device registers.
module lc3_mem_ctrl #(
  parameter logic [15:0] KB_ADDR = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        R_W,
  output logic        R,
  output logic [15:0] mar_out,
  output logic [15:0] mdr_out,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
);

  // state | meaning
  // IDLE  | MAR/MDR loadable, waiting for MIO_EN with no load pending
  // REQ   | external memory request outstanding, waiting for mem_ack
  // DONE  | access complete, R held until MIO_EN falls
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        kbsr15;
  logic [15:0] kbdr;
  logic        dsr15;

  logic        sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, is_dev;
  logic        launch, kbdr_rd, ddr_wr, kb_take;
  logic [15:0] dev_rdata;

  assign sel_kbsr = (mar == KB_ADDR);
  assign sel_kbdr = (mar == KB_ADDR + 16'd2);
  assign sel_dsr  = (mar == KB_ADDR + 16'd4);
  assign sel_ddr  = (mar == KB_ADDR + 16'd6);
  assign is_dev   = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

  assign launch   = (state == IDLE) && MIO_EN && !LD_MAR && !LD_MDR;
  assign kbdr_rd  = launch && sel_kbdr && !R_W;
  assign ddr_wr   = launch && sel_ddr && R_W;
  // A KBDR read on the same edge frees the slot, so the incoming character is kept.
  assign kb_take  = kb_valid && (!kbsr15 || kbdr_rd);

  always_comb begin
    dev_rdata = 16'h0000;
    if (sel_kbsr)
      dev_rdata = {kbsr15, 15'b0};
    else if (sel_kbdr)
      dev_rdata = kbdr;
    else if (sel_dsr)
      dev_rdata = {dsr15, 15'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mar     <= 16'h0000;
      mdr     <= 16'h0000;
      R       <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LD_MAR) mar <= bus_in;
          if (LD_MDR) mdr <= bus_in;
          if (launch) begin
            if (is_dev) begin
              if (!R_W) mdr <= dev_rdata;
              R     <= 1'b1;
              state <= DONE;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= R_W;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) mdr <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            R       <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (LD_MAR) mar <= bus_in;
          if (LD_MDR) mdr <= bus_in;
          if (!MIO_EN) begin
            R     <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          R       <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbsr15     <= 1'b0;
      kbdr       <= 16'h0000;
      dsr15      <= 1'b1;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
    end else begin
      disp_valid <= 1'b0;
      if (kb_take) begin
        kbsr15 <= 1'b1;
        kbdr   <= {8'h00, kb_data};
      end else if (kbdr_rd) begin
        kbsr15 <= 1'b0;
      end
      // Ready returns only after the strobe cycle has passed.
      if (ddr_wr && dsr15) begin
        disp_data  <= mdr[7:0];
        disp_valid <= 1'b1;
        dsr15      <= 1'b0;
      end else if (!dsr15 && !disp_valid && disp_ready) begin
        dsr15 <= 1'b1;
      end
    end
  end

  assign mar_out   = mar;
  assign mdr_out   = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: expected MDR per access goes through a scoreboard queue.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        LD_MAR, LD_MDR, MIO_EN, R_W;
  logic        R;
  logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [15:0] sb_q[$];
  string       sb_tag[$];

  lc3_mem_ctrl #(.KB_ADDR(16'hFE00)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .R_W(R_W), .R(R), .mar_out(mar_out), .mdr_out(mdr_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (disp_valid === 1'b1) pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; LD_MAR = 1'b1;
    step();
    LD_MAR = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus_in = v; LD_MDR = 1'b1;
    step();
    LD_MDR = 1'b0;
  endtask

  task automatic do_access(input string tag, input logic we, input int lat,
                           input logic [15:0] rdata, input logic [15:0] exp_mdr,
                           input logic [15:0] exp_addr, input int exp_cyc);
    int          cyc;
    int          reqcyc;
    logic [15:0] exp_v;
    string       t;
    sb_q.push_back(exp_mdr);
    sb_tag.push_back(tag);
    MIO_EN = 1'b1; R_W = we; cyc = 0; reqcyc = 0;
    while (R !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
      kb_valid = 1'b0;
      if (mem_req === 1'b1) begin
        reqcyc++;
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_we"}, mem_we, we);
        if (we) chk({tag, "_wdata"}, mem_wdata, exp_mdr);
        if (reqcyc == lat) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
      end
    end
    mem_ack = 1'b0;
    chk({tag, "_lat"}, cyc, exp_cyc);
    if (lat > 0) chk({tag, "_reqcyc"}, reqcyc, lat);
    if (R === 1'b1 && sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      t = sb_tag.pop_front();
      chk({t, "_mdr"}, mdr_out, exp_v);
    end else begin
      chk({tag, "_timeout"}, {31'b0, R}, 32'd1);
      void'(sb_q.pop_front());
      void'(sb_tag.pop_front());
    end
  endtask

  task automatic hold_release(input string tag);
    step();
    chk({tag, "_hold_r"}, R, 1'b1);
    chk({tag, "_hold_noreq"}, mem_req, 1'b0);
    MIO_EN = 1'b0;
    step();
    chk({tag, "_release_r"}, R, 1'b0);
  endtask

  initial begin
    rst = 1'b1; bus_in = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0;
    mem_rdata = '0; mem_ack = 0; kb_valid = 0; kb_data = '0; disp_ready = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_r", R, 1'b0);
    chk("rst_mar", mar_out, 16'h0000);
    chk("rst_mdr", mdr_out, 16'h0000);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_disp_valid", disp_valid, 1'b0);
    chk("rst_disp_data", disp_data, 8'h00);

    // Reset in the middle of an outstanding request, then a stray late ack.
    load_mar(16'h5000);
    MIO_EN = 1'b1; R_W = 1'b0;
    step();
    chk("midreq_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midreq_rst_req", mem_req, 1'b0);
    chk("midreq_rst_r", R, 1'b0);
    chk("midreq_rst_mar", mar_out, 16'h0000);
    #1 rst = 1'b0;
    MIO_EN = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    chk("late_ack_mdr", mdr_out, 16'h0000);
    chk("late_ack_r", R, 1'b0);
    chk("late_ack_req", mem_req, 1'b0);

    load_mar(16'h3000);
    do_access("mem_rd", 1'b0, 3, 16'hBEEF, 16'hBEEF, 16'h3000, 4);
    hold_release("mem_rd");

    load_mar(16'h4000);
    load_mdr(16'h1234);
    do_access("mem_wr", 1'b1, 1, 16'h0000, 16'h1234, 16'h4000, 2);
    hold_release("mem_wr");

    // Keyboard: first char latched, second dropped as overrun.
    kb_valid = 1'b1; kb_data = 8'h41;
    step();
    kb_valid = 1'b1; kb_data = 8'h42;
    step();
    kb_valid = 1'b0;
    load_mar(16'hFE00);
    do_access("kbsr_set", 1'b0, 0, 16'h0, 16'h8000, 16'hFE00, 1);
    hold_release("kbsr_set");
    load_mar(16'hFE02);
    do_access("kbdr_rd", 1'b0, 0, 16'h0, 16'h0041, 16'hFE02, 1);
    hold_release("kbdr_rd");
    load_mar(16'hFE00);
    do_access("kbsr_clr", 1'b0, 0, 16'h0, 16'h0000, 16'hFE00, 1);
    hold_release("kbsr_clr");

    // Same-edge KBDR read and new character.
    kb_valid = 1'b1; kb_data = 8'h43;
    step();
    kb_valid = 1'b0;
    load_mar(16'hFE02);
    kb_valid = 1'b1; kb_data = 8'h44;
    do_access("kbdr_same", 1'b0, 0, 16'h0, 16'h0043, 16'hFE02, 1);
    hold_release("kbdr_same");
    load_mar(16'hFE00);
    do_access("kbsr_same", 1'b0, 0, 16'h0, 16'h8000, 16'hFE00, 1);
    hold_release("kbsr_same");
    load_mar(16'hFE02);
    do_access("kbdr_new", 1'b0, 0, 16'h0, 16'h0044, 16'hFE02, 1);
    hold_release("kbdr_new");

    // Display write, busy read, dropped write, ready restore.
    load_mdr(16'h0058);
    load_mar(16'hFE06);
    do_access("ddr_wr", 1'b1, 0, 16'h0, 16'h0058, 16'hFE06, 1);
    chk("ddr_wr_valid", disp_valid, 1'b1);
    chk("ddr_wr_data", disp_data, 8'h58);
    hold_release("ddr_wr");
    chk("ddr_wr_pulse_gone", disp_valid, 1'b0);
    load_mar(16'hFE04);
    do_access("dsr_busy", 1'b0, 0, 16'h0, 16'h0000, 16'hFE04, 1);
    hold_release("dsr_busy");
    load_mdr(16'h0059);
    load_mar(16'hFE06);
    do_access("ddr_drop", 1'b1, 0, 16'h0, 16'h0059, 16'hFE06, 1);
    chk("ddr_drop_valid", disp_valid, 1'b0);
    chk("ddr_drop_data", disp_data, 8'h58);
    hold_release("ddr_drop");
    chk("disp_pulses", pulses, 1);
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    load_mar(16'hFE04);
    do_access("dsr_ready", 1'b0, 0, 16'h0, 16'h8000, 16'hFE04, 1);
    hold_release("dsr_ready");
    load_mar(16'hFE06);
    do_access("ddr_rd", 1'b0, 0, 16'h0, 16'h0000, 16'hFE06, 1);
    hold_release("ddr_rd");

    // MIO_EN with LD_MAR in IDLE: launch waits, then uses the new MAR.
    bus_in = 16'h3100; LD_MAR = 1'b1; MIO_EN = 1'b1; R_W = 1'b0;
    step();
    LD_MAR = 1'b0;
    chk("ldmar_block_req", mem_req, 1'b0);
    chk("ldmar_block_r", R, 1'b0);
    chk("ldmar_block_mar", mar_out, 16'h3100);
    do_access("ldmar_rd", 1'b0, 1, 16'h1111, 16'h1111, 16'h3100, 2);
    hold_release("ldmar_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
